// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmit path.
//   tx_state_t : framing FSM state encoding
//   PAR_*      : parity mode constants for the PARITY parameter
//   calc_div   : clock cycles per bit (integer truncation)
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP  = 3'd4
   } tx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   function automatic int calc_div(input int clk_hz, input int bit_rate);
      return clk_hz / bit_rate;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo -- synchronous show-ahead FIFO.
//   CLK, RST : clock, asynchronous active-high reset
//   wr_data, wr : write word / strobe (accepted when not full, or when a read
//                 happens in the same cycle)
//   rd       : pop strobe (ignored when empty); rd_data shows the head word
//   full, empty, level : occupancy status
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     wr,
   input  logic                     rd,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   LVL_ONE = 1;
   localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_ok;
   logic             rd_ok;

   // Status comes from the occupancy count: with power-of-two depth the
   // pointers are equal both when empty and when full.
   assign full  = (level == LVL_MAX);
   assign empty = (level == '0);

   assign rd_ok = rd && !empty;
   // A pop in the same cycle frees a slot, so a full FIFO can still take a write.
   assign wr_ok = wr && (!full || rd_ok);

   assign rd_data = mem[rd_ptr];

   always_ff @(posedge CLK) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
         case ({wr_ok, rd_ok})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- buffered UART transmitter.
//   CLK, RST : clock, asynchronous active-high reset
//   DATA, WR : word to enqueue / write strobe
//   TX       : serial line, idle high
//   FULL, EMPTY, LEVEL : FIFO status
//   BUSY     : high while a frame is on TX
//   OVF      : sticky dropped-write flag, present only when the macro
//              UART_TX_FIFO_OVF_EN is defined
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 12_000_000,
   parameter int BIT_RATE   = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [DATA_BITS-1:0]          DATA,
   input  logic                          WR,
   output logic                          TX,
   output logic                          FULL,
   output logic                          EMPTY,
   output logic                          BUSY,
   output logic [$clog2(FIFO_DEPTH):0]   LEVEL
`ifdef UART_TX_FIFO_OVF_EN
   ,
   output logic                          OVF
`endif
);

   localparam int DIV = calc_div(CLK_HZ, BIT_RATE);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [DW-1:0] DIV_ONE   = 1;
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic          PAR_INV   = (PARITY == PAR_ODD);

   tx_state_t            state;
   tx_state_t            state_d;
   logic [DW-1:0]        div_cnt;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 tick;
   logic                 pop;
   logic                 tx_d;
   logic                 tx_q;
   logic                 busy_q;
   logic [DATA_BITS-1:0] fifo_data;

   uart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RST     (RST),
      .wr_data (DATA),
      .wr      (WR),
      .rd      (pop),
      .rd_data (fifo_data),
      .full    (FULL),
      .empty   (EMPTY),
      .level   (LEVEL)
   );

   assign tick = (div_cnt == DIV_LAST);

   // State register plus per-bit datapath.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= ST_IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
      end else begin
         state <= state_d;
         if (state == ST_IDLE || tick) div_cnt <= '0;
         else                          div_cnt <= div_cnt + DIV_ONE;
         if (state_d != state) bit_cnt <= '0;
         else if (tick)        bit_cnt <= bit_cnt + 4'd1;
         if (pop) begin
            shreg   <= fifo_data;
            par_bit <= (^fifo_data) ^ PAR_INV;
         end else if (state == ST_DATA && tick) begin
            shreg <= shreg >> 1;
         end
      end
   end

   // Next state. STOP chains straight into START when more data is queued
   // so back-to-back frames have no idle gap.
   always_comb begin
      state_d = state;
      pop     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!EMPTY) begin
               pop     = 1'b1;
               state_d = ST_START;
            end
         end
         ST_START: if (tick) state_d = ST_DATA;
         ST_DATA: begin
            if (tick && bit_cnt == DATA_LAST)
               state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
         end
         ST_PAR: if (tick) state_d = ST_STOP;
         ST_STOP: begin
            if (tick && bit_cnt == STOP_LAST) begin
               if (!EMPTY) begin
                  pop     = 1'b1;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Line level for the current state.
   always_comb begin
      tx_d = 1'b1;
      case (state)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shreg[0];
         ST_PAR:   tx_d = par_bit;
         default:  tx_d = 1'b1;
      endcase
   end

   // TX and BUSY are registered so the line is glitch-free; they trail the
   // state by one cycle, which puts the start bit two edges after the write.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tx_q   <= 1'b1;
         busy_q <= 1'b0;
      end else begin
         tx_q   <= tx_d;
         busy_q <= (state != ST_IDLE);
      end
   end

   assign TX   = tx_q;
   assign BUSY = busy_q;

`ifdef UART_TX_FIFO_OVF_EN
   logic ovf_q;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                      ovf_q <= 1'b0;
      else if (WR && FULL && !pop)  ovf_q <= 1'b1;
   end
   assign OVF = ovf_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo -- directed bench for uart_tx_fifo.
// Instances: 0 = defaults (8N1, DIV 1250), 1 = 8E2 DIV 10,
// 2 = 8O1 DIV 10, 3 = 8N1 DIV 10 for FIFO / reset scenarios.
module tb_uart_tx_fifo;

   logic       clk;
   logic [3:0] rst_v;
   logic [3:0] wr_v;
   logic [7:0] data_v [4];
   logic [3:0] tx_v, full_v, empty_v, busy_v;
   logic [4:0] level_v [4];
`ifdef UART_TX_FIFO_OVF_EN
   logic [3:0] ovf_v;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   logic [15:0] exp_q [$];

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   uart_tx_fifo dut0 (
      .CLK(clk), .RST(rst_v[0]), .DATA(data_v[0]), .WR(wr_v[0]), .TX(tx_v[0]),
      .FULL(full_v[0]), .EMPTY(empty_v[0]), .BUSY(busy_v[0]), .LEVEL(level_v[0])
`ifdef UART_TX_FIFO_OVF_EN
      , .OVF(ovf_v[0])
`endif
   );

   uart_tx_fifo #(.CLK_HZ(1000), .BIT_RATE(100), .PARITY(2), .STOP_BITS(2)) dut1 (
      .CLK(clk), .RST(rst_v[1]), .DATA(data_v[1]), .WR(wr_v[1]), .TX(tx_v[1]),
      .FULL(full_v[1]), .EMPTY(empty_v[1]), .BUSY(busy_v[1]), .LEVEL(level_v[1])
`ifdef UART_TX_FIFO_OVF_EN
      , .OVF(ovf_v[1])
`endif
   );

   uart_tx_fifo #(.CLK_HZ(1000), .BIT_RATE(100), .PARITY(1)) dut2 (
      .CLK(clk), .RST(rst_v[2]), .DATA(data_v[2]), .WR(wr_v[2]), .TX(tx_v[2]),
      .FULL(full_v[2]), .EMPTY(empty_v[2]), .BUSY(busy_v[2]), .LEVEL(level_v[2])
`ifdef UART_TX_FIFO_OVF_EN
      , .OVF(ovf_v[2])
`endif
   );

   uart_tx_fifo #(.CLK_HZ(1000), .BIT_RATE(100)) dut3 (
      .CLK(clk), .RST(rst_v[3]), .DATA(data_v[3]), .WR(wr_v[3]), .TX(tx_v[3]),
      .FULL(full_v[3]), .EMPTY(empty_v[3]), .BUSY(busy_v[3]), .LEVEL(level_v[3])
`ifdef UART_TX_FIFO_OVF_EN
      , .OVF(ovf_v[3])
`endif
   );

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // ---------------- drivers ----------------
   // Called at a negedge; the word is sampled on the following posedge.
   task automatic write_word(input int idx, input logic [7:0] d);
      data_v[idx] = d;
      wr_v[idx]   = 1'b1;
      @(negedge clk);
      wr_v[idx]   = 1'b0;
   endtask

   // Waits (up to budget negedges) for a start bit, then samples the frame
   // at mid-bit. Returns with the last frame cycle just sampled.
   task automatic capture(input int idx, input int div, input int nbits, input int budget,
                          output logic [15:0] bits, output int busy_n);
      int waited = 0;
      bits   = '0;
      busy_n = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (tx_v[idx] !== 1'b0 && waited < budget);
      check("start_seen", tx_v[idx], 0);
      if (tx_v[idx] !== 1'b0) return;
      for (int c = 0; c < nbits * div; c++) begin
         if (c > 0) @(negedge clk);
         if (busy_v[idx] === 1'b1) busy_n++;
         if (c % div == div / 2) bits[c / div] = tx_v[idx];
      end
   endtask

   function automatic logic [15:0] frame_8n1(input logic [7:0] d);
      return {6'b0, 1'b1, d, 1'b0};
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] bits;
      int          busy_n;
      int          waited;
      int          lows;

      rst_v = 4'hF;
      wr_v  = 4'h0;
      for (int i = 0; i < 4; i++) data_v[i] = 8'h00;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         check($sformatf("rst_tx%0d", i), tx_v[i], 1);
         check($sformatf("rst_empty%0d", i), empty_v[i], 1);
         check($sformatf("rst_full%0d", i), full_v[i], 0);
         check($sformatf("rst_busy%0d", i), busy_v[i], 0);
         check($sformatf("rst_level%0d", i), level_v[i], 0);
`ifdef UART_TX_FIFO_OVF_EN
         check($sformatf("rst_ovf%0d", i), ovf_v[i], 0);
`endif
      end
      rst_v = 4'h0;
      repeat (2) @(negedge clk);

      // Defaults: 0x41, start bit on the second edge after the write edge.
      write_word(0, 8'h41);
      check("lat_e0_tx", tx_v[0], 1);
      @(negedge clk);
      check("lat_e1_tx", tx_v[0], 1);
      check("lat_e1_busy", busy_v[0], 0);
      capture(0, 1250, 10, 1, bits, busy_n);
      check("frame_41", bits, 16'h0282);
      check("frame_41_len", busy_n, 12500);
      @(negedge clk);
      check("after_41_busy", busy_v[0], 0);
      check("after_41_tx", tx_v[0], 1);

      // 8E2, 0x07 -> parity 1, two stop bits.
      write_word(1, 8'h07);
      capture(1, 10, 12, 5, bits, busy_n);
      check("frame_8e2", bits, 16'h0E0E);
      check("frame_8e2_len", busy_n, 120);

      // 8O1, 0x07 -> parity 0.
      write_word(2, 8'h07);
      capture(2, 10, 11, 5, bits, busy_n);
      check("frame_8o1", bits, 16'h040E);
      check("frame_8o1_len", busy_n, 110);

      // FIFO fill: one word in flight, then 0x40..0x50 back to back.
      write_word(3, 8'h3F);
      waited = 0;
      while (tx_v[3] !== 1'b0 && waited < 5) begin
         @(negedge clk);
         waited++;
      end
      check("burst_start", tx_v[3], 0);
      // Frame cycle 0 here.
      for (int k = 0; k < 17; k++) begin
         data_v[3] = 8'(8'h40 + k);
         wr_v[3]   = 1'b1;
         @(negedge clk);
         if (k == 15) begin
            check("fill_level16", level_v[3], 16);
            check("fill_full", full_v[3], 1);
         end
      end
      wr_v[3] = 1'b0;
      check("drop_level", level_v[3], 16);
`ifdef UART_TX_FIFO_OVF_EN
      check("ovf_set", ovf_v[3], 1);
`endif
      // Frame cycle 17 now; write lands on the pop edge (end of cycle 98).
      repeat (98 - 17) @(negedge clk);
      check("prepop_level", level_v[3], 16);
      data_v[3] = 8'h51;
      wr_v[3]   = 1'b1;
      @(negedge clk);
      wr_v[3]   = 1'b0;
      check("pop_wr_level", level_v[3], 16);
      check("pop_wr_full", full_v[3], 1);
`ifdef UART_TX_FIFO_OVF_EN
      check("ovf_held", ovf_v[3], 1);
`endif
      for (int k = 0; k < 16; k++) exp_q.push_back(frame_8n1(8'(8'h40 + k)));
      exp_q.push_back(frame_8n1(8'h51));
      while (exp_q.size() > 0) begin
         logic [15:0] exp;
         exp = exp_q.pop_front();
         capture(3, 10, 10, 1, bits, busy_n);
         check($sformatf("burst_frame_%0h", exp[8:1]), bits, exp);
      end
      @(negedge clk);
      check("burst_done_busy", busy_v[3], 0);
      check("burst_done_empty", empty_v[3], 1);

      // Reset mid-DATA of 0x5A with three words queued.
      write_word(3, 8'h5A);
      data_v[3] = 8'h01; wr_v[3] = 1'b1; @(negedge clk);
      data_v[3] = 8'h02; @(negedge clk);
      data_v[3] = 8'h03; @(negedge clk);
      wr_v[3] = 1'b0;
      waited = 0;
      while (tx_v[3] !== 1'b0 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      repeat (30) @(negedge clk);
      check("pre_rst_level", level_v[3], 3);
      check("pre_rst_busy", busy_v[3], 1);
`ifdef UART_TX_FIFO_OVF_EN
      check("pre_rst_ovf", ovf_v[3], 1);
`endif
      #2 rst_v[3] = 1'b1;
      #1;
      check("mid_rst_tx", tx_v[3], 1);
      check("mid_rst_level", level_v[3], 0);
      check("mid_rst_busy", busy_v[3], 0);
      check("mid_rst_empty", empty_v[3], 1);
`ifdef UART_TX_FIFO_OVF_EN
      check("mid_rst_ovf", ovf_v[3], 0);
`endif
      @(negedge clk);
      rst_v[3] = 1'b0;
      lows = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (tx_v[3] !== 1'b1 || busy_v[3] !== 1'b0) lows++;
      end
      check("post_rst_quiet", lows, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
